// File: rtl/shift_seq_if.sv
// shift_seq_if: request/result bundle for the long-shift sequencer.
//   start, op, count, ar_in, arx_in : request from the microcode loop
//   ar_out, arx_out, busy, done, ovf : registered result/status from the sequencer
// master = microcode side (drives requests), slave = shift_seq.
interface shift_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [8:0]  count;
  logic [0:35] ar_in;
  logic [0:35] arx_in;
  logic [0:35] ar_out;
  logic [0:35] arx_out;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (
    output start, op, count, ar_in, arx_in,
    input  ar_out, arx_out, busy, done, ovf
  );

  modport slave (
    input  start, op, count, ar_in, arx_in,
    output ar_out, arx_out, busy, done, ovf
  );
endinterface

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle long-shift sequencer for LSH/ASH/ROT and the
// double-word LSHC/ASHC/ROTC forms. Iterates the AR!ARX funnel in steps of
// at most 36 positions per cycle (up to 8 steps for a 256-position count).
// Ports:
//   clk   - EBOX clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - shift_seq_if.slave: start/op/count/ar_in/arx_in in,
//           ar_out/arx_out/busy/done/ovf out (all registered)
module shift_seq (
  input  logic       clk,
  input  logic       rst_n,
  shift_seq_if.slave bus
);
  localparam int unsigned WORD_W   = 36;
  localparam int unsigned DBL_W    = 72;
  localparam int unsigned CNT_W    = 9;
  localparam int unsigned STEP_W   = 6;
  localparam int unsigned MAX_STEP = 36;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  logic [WORD_W-1:0] ar_q, arx_q, ar_n, arx_n;
  logic [2:0]        op_q;
  logic              dir_q;            // 1 = right shift (negative count)
  logic [CNT_W-1:0]  rem_q, rem_d, mag_c;
  logic [STEP_W-1:0] step_k;
  logic              ovf_q, busy_q, done_q, step_ovf;

  logic              sign;
  logic [DBL_W-1:0]  dw;
  logic [WORD_W-1:0] ovf_mask;
  logic [70:0]       t_single;         // {shifted-out, 35-bit magnitude}
  logic [105:0]      t_double;         // {shifted-out, 70-bit magnitude}
  logic              ovf_single, ovf_double;
  logic signed [WORD_W-1:0] ar_s;
  logic signed [70:0]       ashc_s;
  logic [WORD_W-1:0] sw_ash_r, sw_rot_l, sw_rot_r;
  logic [70:0]       dw_ash_r;
  logic [DBL_W-1:0]  dw_rot_l, dw_rot_r;

  // |count| as 9-bit unsigned; -256 maps to 256
  always_comb begin
    mag_c = bus.count[8] ? CNT_W'(~bus.count + 9'd1) : bus.count;
  end

  // Step size and remaining count after this step
  always_comb begin
    step_k = (rem_q > CNT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(rem_q);
    rem_d  = rem_q - CNT_W'(step_k);
  end

  // One shift step of up to 36 positions
  always_comb begin
    sign     = ar_q[WORD_W-1];
    dw       = {ar_q, arx_q};
    ar_s     = ar_q;
    ashc_s   = {ar_q, arx_q[34:0]};
    // low step_k bits of the shifted-out field are the bits that left bit 1
    ovf_mask = ~({WORD_W{1'b1}} << step_k);
    t_single = {36'b0, ar_q[34:0]} << step_k;
    t_double = {36'b0, ar_q[34:0], arx_q[34:0]} << step_k;
    ovf_single = |((t_single[70:35] ^ {WORD_W{sign}}) & ovf_mask);
    ovf_double = |((t_double[105:70] ^ {WORD_W{sign}}) & ovf_mask);
    sw_ash_r = ar_s >>> step_k;
    dw_ash_r = ashc_s >>> step_k;
    // k=0 and k=W both reduce to identity since an over-width shift yields 0
    sw_rot_l = (ar_q << step_k) | (ar_q >> (6'd36 - step_k));
    sw_rot_r = (ar_q >> step_k) | (ar_q << (6'd36 - step_k));
    dw_rot_l = (dw << step_k) | (dw >> (7'd72 - 7'(step_k)));
    dw_rot_r = (dw >> step_k) | (dw << (7'd72 - 7'(step_k)));

    ar_n     = ar_q;
    arx_n    = arx_q;
    step_ovf = 1'b0;

    if (!op_q[2]) begin
      case (op_q[1:0])
        2'b01: begin
          ar_n     = dir_q ? sw_ash_r : {sign, t_single[34:0]};
          step_ovf = !dir_q && ovf_single;
        end
        2'b10:   ar_n = dir_q ? sw_rot_r : sw_rot_l;
        default: ar_n = dir_q ? (ar_q >> step_k) : (ar_q << step_k);
      endcase
    end else begin
      case (op_q[1:0])
        2'b01: begin
          if (dir_q) begin
            ar_n  = dw_ash_r[70:35];
            arx_n = {sign, dw_ash_r[34:0]};
          end else begin
            ar_n     = {sign, t_double[69:35]};
            arx_n    = {sign, t_double[34:0]};
            step_ovf = ovf_double;
          end
        end
        2'b10:   {ar_n, arx_n} = dir_q ? dw_rot_r : dw_rot_l;
        default: {ar_n, arx_n} = dir_q ? (dw >> step_k) : (dw << step_k);
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (rem_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/result registers and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q   <= '0;
      arx_q  <= '0;
      op_q   <= '0;
      dir_q  <= 1'b0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == SHIFT);
      done_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ar_q  <= bus.ar_in;
            arx_q <= bus.arx_in;
            op_q  <= bus.op;
            dir_q <= bus.count[8];
            rem_q <= mag_c;
            ovf_q <= 1'b0;
          end
        end
        SHIFT: begin
          ar_q  <= ar_n;
          arx_q <= arx_n;
          rem_q <= rem_d;
          if (step_ovf) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ar_out  = ar_q;
  assign bus.arx_out = arx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard bench for shift_seq. The driver pushes the
// reference-model result for each accepted request; a monitor pops and
// compares whenever done is presented.
module tb_shift_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [35:0] ar;
    logic [35:0] arx;
    logic        ovf;
    int          done_cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  shift_seq_if bus_if ();

  shift_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mag_of(input logic [8:0] cnt);
    return cnt[8] ? 512 - int'(cnt) : int'(cnt);
  endfunction

  function automatic int nsteps(input logic [8:0] cnt);
    int m;
    m = mag_of(cnt);
    return (m == 0) ? 1 : (m + 35) / 36;
  endfunction

  function automatic logic [35:0] rnd36();
    return 36'({$urandom(), $urandom()});
  endfunction

  // Bit-at-a-time reference: apply the whole count as m single-position moves
  function automatic void ref_model(input logic [2:0] op, input logic [8:0] cnt,
                                    input logic [35:0] a_in, input logic [35:0] x_in,
                                    output logic [35:0] ra, output logic [35:0] rx,
                                    output logic rovf);
    int m;
    bit left;
    logic [35:0] a;
    logic [71:0] d;
    logic [69:0] mg;
    logic sgn;
    m    = mag_of(cnt);
    left = (cnt[8] == 1'b0);
    a    = a_in;
    d    = {a_in, x_in};
    sgn  = a_in[35];
    mg   = {a_in[34:0], x_in[34:0]};
    rovf = 1'b0;
    ra   = a_in;
    rx   = x_in;
    if (!op[2]) begin
      if (op[1:0] == 2'b01) begin
        for (int i = 0; i < m; i++) begin
          if (left) begin
            if (a[34] != sgn) rovf = 1'b1;
            a = {sgn, a[33:0], 1'b0};
          end else begin
            a = {sgn, a[35:1]};
          end
        end
      end else if (op[1:0] == 2'b10) begin
        for (int i = 0; i < m % 36; i++)
          a = left ? {a[34:0], a[35]} : {a[0], a[35:1]};
      end else begin
        for (int i = 0; i < m; i++)
          a = left ? (a << 1) : (a >> 1);
      end
      ra = a;
    end else begin
      if (op[1:0] == 2'b01) begin
        for (int i = 0; i < m; i++) begin
          if (left) begin
            if (mg[69] != sgn) rovf = 1'b1;
            mg = {mg[68:0], 1'b0};
          end else begin
            mg = {sgn, mg[69:1]};
          end
        end
        ra = {sgn, mg[69:35]};
        rx = {sgn, mg[34:0]};
      end else begin
        if (op[1:0] == 2'b10) begin
          for (int i = 0; i < m % 72; i++)
            d = left ? {d[70:0], d[71]} : {d[0], d[71:1]};
        end else begin
          for (int i = 0; i < m; i++)
            d = left ? (d << 1) : (d >> 1);
        end
        ra = d[71:36];
        rx = d[35:0];
      end
    end
  endfunction

  task automatic drive(input logic [2:0] op, input logic [8:0] cnt,
                       input logic [35:0] a, input logic [35:0] x);
    bus_if.op     = op;
    bus_if.count  = cnt;
    bus_if.ar_in  = a;
    bus_if.arx_in = x;
  endtask

  function automatic exp_t make_exp(input string tag, input logic [2:0] op, input logic [8:0] cnt,
                                    input logic [35:0] a, input logic [35:0] x, input int dcyc);
    exp_t e;
    ref_model(op, cnt, a, x, e.ar, e.arx, e.ovf);
    e.done_cyc = dcyc;
    e.tag      = tag;
    return e;
  endfunction

  // Issue one request; returns at the first IDLE cycle after done.
  // inject: pulse start with different operands while SHIFT is running.
  task automatic issue(input string tag, input logic [2:0] op, input logic [8:0] cnt,
                       input logic [35:0] a, input logic [35:0] x, input bit inject);
    exp_t e;
    int n;
    n = nsteps(cnt);
    @(negedge clk);
    drive(op, cnt, a, x);
    bus_if.start = 1'b1;
    e = make_exp(tag, op, cnt, a, x, cyc + 1 + n);
    sb.push_back(e);
    @(negedge clk);
    bus_if.start = 1'b0;
    chk({tag, "_busy"}, 72'(bus_if.busy), 72'(1'b1));
    drive(3'($urandom_range(0, 7)), 9'($urandom), rnd36(), rnd36());
    if (inject && n >= 2) begin
      @(negedge clk);
      bus_if.start  = 1'b1;
      bus_if.ar_in  = ~a;
      bus_if.count  = 9'd3;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (n - 1) @(negedge clk);
    end else begin
      repeat (n + 1) @(negedge clk);
    end
    chk({tag, "_hold_ar"}, 72'(bus_if.ar_out), 72'(e.ar));
    chk({tag, "_idle_busy"}, 72'(bus_if.busy), 72'(1'b0));
  endtask

  // start held high through DONE: second request accepted in the first IDLE cycle
  task automatic b2b(input logic [2:0] op1, input logic [8:0] c1, input logic [35:0] a1, input logic [35:0] x1,
                     input logic [2:0] op2, input logic [8:0] c2, input logic [35:0] a2, input logic [35:0] x2);
    int n1, n2, c;
    n1 = nsteps(c1);
    n2 = nsteps(c2);
    @(negedge clk);
    drive(op1, c1, a1, x1);
    bus_if.start = 1'b1;
    c = cyc;
    sb.push_back(make_exp("b2b_first", op1, c1, a1, x1, c + 1 + n1));
    sb.push_back(make_exp("b2b_second", op2, c2, a2, x2, c + 1 + n1 + 2 + n2));
    @(negedge clk);
    drive(op2, c2, a2, x2);
    repeat (n1 + 2) @(negedge clk);
    bus_if.start = 1'b0;
    repeat (n2 + 1) @(negedge clk);
  endtask

  // Monitor: compare every presented result against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus_if.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_ar"},  72'(bus_if.ar_out),  72'(mon_e.ar));
        chk({mon_e.tag, "_arx"}, 72'(bus_if.arx_out), 72'(mon_e.arx));
        chk({mon_e.tag, "_ovf"}, 72'(bus_if.ovf),     72'(mon_e.ovf));
        chk({mon_e.tag, "_cyc"}, 72'(cyc),            72'(mon_e.done_cyc));
      end
    end
  end

  initial begin
    bit seen;
    logic [35:0] ra, rx;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    drive(3'd0, 9'd0, 36'd0, 36'd0);
    repeat (3) @(negedge clk);
    chk("rst_ar",   72'(bus_if.ar_out),  72'(0));
    chk("rst_arx",  72'(bus_if.arx_out), 72'(0));
    chk("rst_busy", 72'(bus_if.busy),    72'(0));
    chk("rst_done", 72'(bus_if.done),    72'(0));
    chk("rst_ovf",  72'(bus_if.ovf),     72'(0));
    rst_n = 1'b1;

    issue("lsh35",       3'd0, 9'd35,    36'o000000000001, rnd36(), 1'b0);
    issue("rotc72",      3'd6, 9'd72,    36'o123456701234, 36'o765432107654, 1'b0);
    issue("rotc_m256",   3'd6, 9'h100,   36'o123456701234, 36'o765432107654, 1'b0);
    issue("ash_ovf",     3'd1, 9'd1,     36'o200000000000, rnd36(), 1'b0);
    issue("ashc_m256",   3'd5, 9'h100,   36'o400000000000, 36'd0, 1'b0);
    issue("lsh_m36",     3'd0, 9'(-36),  rnd36(), rnd36(), 1'b0);
    issue("rot_zero",    3'd2, 9'd0,     rnd36(), rnd36(), 1'b0);
    issue("lshc_zero",   3'd4, 9'd0,     rnd36(), rnd36(), 1'b0);
    issue("ash_neg_l40", 3'd1, 9'd40,    36'o777777777770, rnd36(), 1'b0);
    issue("ashc_l255",   3'd5, 9'd255,   36'o000000000000, 36'o000000000001, 1'b0);
    issue("lsh_inject",  3'd0, 9'd200,   rnd36(), rnd36(), 1'b1);
    issue("op7_lshc",    3'd7, 9'(-100), rnd36(), rnd36(), 1'b0);

    b2b(3'd2, 9'd50, rnd36(), rnd36(), 3'd5, 9'(-73), rnd36(), rnd36());

    // Reset during step 3 of a 200-position shift: no done, outputs cleared
    @(negedge clk);
    drive(3'd0, 9'd200, 36'o777777777777, 36'o123);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ar",   72'(bus_if.ar_out),  72'(0));
    chk("midrst_arx",  72'(bus_if.arx_out), 72'(0));
    chk("midrst_busy", 72'(bus_if.busy),    72'(0));
    chk("midrst_ovf",  72'(bus_if.ovf),     72'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.done) seen = 1'b1;
    end
    chk("midrst_no_done", 72'(seen), 72'(0));

    for (int i = 0; i < 40; i++) begin
      issue($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 9'($urandom),
            rnd36(), rnd36(), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 72'(sb.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
